// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Arbitrates two requesters (register-file read response, one
//               word; ALU result, two words) onto a single TX FIFO write port.
//               A granted transaction is captured into a holding register and
//               then written word by word, stalling while the FIFO is full.
//               Optional feature macro: ARB_RR_EN. When defined, simultaneous
//               requests are resolved by a 1-bit round-robin pointer. When
//               undefined, RF has fixed priority over ALU.
// Ports       : clk       - block clock, rising edge
//               rst       - asynchronous active-high reset
//               req_rf    - RF requester, one word to send
//               rf_data   - RF word, valid while req_rf is high
//               gnt_rf    - one-cycle accept pulse to RF requester
//               req_alu   - ALU requester, two words to send
//               alu_data  - ALU result, valid while req_alu is high
//               gnt_alu   - one-cycle accept pulse to ALU requester
//               fifo_full - TX FIFO full flag (write-domain synchronised)
//               wr_data   - FIFO write data
//               wr_inc    - FIFO write strobe, one word per high cycle
//               busy      - high whenever a transaction is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_rf,
  input  logic [DATA_WIDTH-1:0]    rf_data,
  output logic                     gnt_rf,
  input  logic                     req_alu,
  input  logic [ALU_OUT_WIDTH-1:0] alu_data,
  output logic                     gnt_alu,
  input  logic                     fifo_full,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_inc,
  output logic                     busy
);

  localparam int C_HOLD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RF     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_HOLD_W-1:0] r_hold;
  logic                w_pick_alu;

`ifdef ARB_RR_EN
  // Pointer high means ALU is favoured on a tie; it flips to the loser
  // after every grant, so a lone request is still granted immediately.
  logic r_rr_alu;

  always_comb begin
    w_pick_alu = req_alu && (!req_rf || r_rr_alu);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_alu <= 1'b0;
    end else if (r_state == IDLE && (req_rf || req_alu)) begin
      r_rr_alu <= !w_pick_alu;
    end
  end
`else
  always_comb begin
    w_pick_alu = req_alu && !req_rf;
  end
`endif

  // Next state and outputs. Grants are gated by rst so that a requester
  // holding its request through reset sees no accept pulse.
  always_comb begin
    w_state_nxt = r_state;
    gnt_rf      = 1'b0;
    gnt_alu     = 1'b0;
    wr_inc      = 1'b0;
    wr_data     = '0;
    case (r_state)
      IDLE: begin
        if (!rst && (req_rf || req_alu)) begin
          if (w_pick_alu) begin
            gnt_alu     = 1'b1;
            w_state_nxt = SEND_ALU_LO;
          end else begin
            gnt_rf      = 1'b1;
            w_state_nxt = SEND_RF;
          end
        end
      end
      SEND_RF: begin
        wr_data = r_hold[DATA_WIDTH-1:0];
        wr_inc  = !fifo_full;
        if (!fifo_full) w_state_nxt = IDLE;
      end
      SEND_ALU_LO: begin
        wr_data = r_hold[DATA_WIDTH-1:0];
        wr_inc  = !fifo_full;
        if (!fifo_full) w_state_nxt = SEND_ALU_HI;
      end
      SEND_ALU_HI: begin
        wr_data = r_hold[C_HOLD_W-1:DATA_WIDTH];
        wr_inc  = !fifo_full;
        if (!fifo_full) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Words are sent from this copy, so requester inputs may change freely
  // once the grant has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (gnt_alu) begin
      r_hold <= alu_data;
    end else if (gnt_rf) begin
      r_hold <= {{DATA_WIDTH{1'b0}}, rf_data};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed self-checking bench for fifo_wr_arbiter. Inputs are
//               driven 1 time unit after the rising edge, outputs sampled on
//               the falling edge. Tie-break expectations follow ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rf;
  logic [7:0]  rf_data;
  logic        gnt_rf;
  logic        req_alu;
  logic [15:0] alu_data;
  logic        gnt_alu;
  logic        fifo_full;
  logic [7:0]  wr_data;
  logic        wr_inc;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_rf   (req_rf),
    .rf_data  (rf_data),
    .gnt_rf   (gnt_rf),
    .req_alu  (req_alu),
    .alu_data (alu_data),
    .gnt_alu  (gnt_alu),
    .fifo_full(fifo_full),
    .wr_data  (wr_data),
    .wr_inc   (wr_inc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_rf    = 1'b0;
    req_alu   = 1'b0;
    fifo_full = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_rf    = 1'b1;
    req_alu   = 1'b1;
    rf_data   = 8'hA5;
    alu_data  = 16'h1234;
    fifo_full = 1'b0;
    to_sample();
    total++; if (gnt_rf !== 1'b0) begin bad++; $display("FAIL reset_gnt_rf got=%b exp=0", gnt_rf); end
    total++; if (gnt_alu !== 1'b0) begin bad++; $display("FAIL reset_gnt_alu got=%b exp=0", gnt_alu); end
    total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL reset_wr_inc got=%b exp=0", wr_inc); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    next_cycle();
    rst     = 1'b0;
    req_rf  = 1'b0;
    req_alu = 1'b0;
  endtask

  // Starts in the first cycle after reset release: grant must be immediate.
  task automatic test_rf_single();
    req_rf  = 1'b1;
    rf_data = 8'h5A;
    to_sample();
    total++; if (gnt_rf !== 1'b1) begin bad++; $display("FAIL rf_gnt got=%b exp=1", gnt_rf); end
    total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL rf_grant_cycle_wr_inc got=%b exp=0", wr_inc); end
    next_cycle();
    req_rf  = 1'b0;
    rf_data = 8'hFF;
    to_sample();
    total++; if (wr_inc !== 1'b1) begin bad++; $display("FAIL rf_wr_inc got=%b exp=1", wr_inc); end
    total++; if (wr_data !== 8'h5A) begin bad++; $display("FAIL rf_wr_data got=%h exp=5a", wr_data); end
    total++; if (gnt_rf !== 1'b0) begin bad++; $display("FAIL rf_gnt_in_send got=%b exp=0", gnt_rf); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rf_busy_send got=%b exp=1", busy); end
    next_cycle();
    to_sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rf_busy_idle got=%b exp=0", busy); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rf_idle_wr_data got=%h exp=00", wr_data); end
    next_cycle();
  endtask

  task automatic test_alu_two_words();
    req_alu  = 1'b1;
    alu_data = 16'hBEEF;
    to_sample();
    total++; if (gnt_alu !== 1'b1) begin bad++; $display("FAIL alu_gnt got=%b exp=1", gnt_alu); end
    total++; if (gnt_rf !== 1'b0) begin bad++; $display("FAIL alu_gnt_rf got=%b exp=0", gnt_rf); end
    next_cycle();
    req_alu  = 1'b0;
    alu_data = 16'h0000;
    to_sample();
    total++; if (wr_inc !== 1'b1) begin bad++; $display("FAIL alu_lo_wr_inc got=%b exp=1", wr_inc); end
    total++; if (wr_data !== 8'hEF) begin bad++; $display("FAIL alu_lo_wr_data got=%h exp=ef", wr_data); end
    next_cycle();
    to_sample();
    total++; if (wr_inc !== 1'b1) begin bad++; $display("FAIL alu_hi_wr_inc got=%b exp=1", wr_inc); end
    total++; if (wr_data !== 8'hBE) begin bad++; $display("FAIL alu_hi_wr_data got=%h exp=be", wr_data); end
    next_cycle();
    to_sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL alu_end_busy got=%b exp=0", busy); end
    next_cycle();
  endtask

  task automatic test_stall_hi();
    req_alu   = 1'b1;
    alu_data  = 16'hBEEF;
    fifo_full = 1'b0;
    to_sample();
    total++; if (gnt_alu !== 1'b1) begin bad++; $display("FAIL stall_gnt got=%b exp=1", gnt_alu); end
    next_cycle();
    req_alu = 1'b0;
    to_sample();
    total++; if (wr_data !== 8'hEF) begin bad++; $display("FAIL stall_lo_wr_data got=%h exp=ef", wr_data); end
    next_cycle();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL stall_wr_inc[%0d] got=%b exp=0", i, wr_inc); end
      total++; if (wr_data !== 8'hBE) begin bad++; $display("FAIL stall_wr_data[%0d] got=%h exp=be", i, wr_data); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy[%0d] got=%b exp=1", i, busy); end
      next_cycle();
    end
    fifo_full = 1'b0;
    to_sample();
    total++; if (wr_inc !== 1'b1) begin bad++; $display("FAIL stall_release_wr_inc got=%b exp=1", wr_inc); end
    total++; if (wr_data !== 8'hBE) begin bad++; $display("FAIL stall_release_wr_data got=%h exp=be", wr_data); end
    next_cycle();
    to_sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_end_busy got=%b exp=0", busy); end
    next_cycle();
  endtask

  // Both request; each requester drops its request once granted.
  task automatic test_back_to_back();
    logic [7:0] wr_log [0:7];
    int         n_wr;
    int         alu_gnt_cyc;
    int         overlap;
    logic       g_rf;
    logic       g_alu;
    n_wr        = 0;
    alu_gnt_cyc = -1;
    overlap     = 0;
    do_reset();
    req_rf   = 1'b1;
    rf_data  = 8'h11;
    req_alu  = 1'b1;
    alu_data = 16'h2233;
    for (int c = 0; c < 8; c++) begin
      to_sample();
      g_rf  = gnt_rf;
      g_alu = gnt_alu;
      if (g_rf && g_alu) overlap++;
      if (g_alu && alu_gnt_cyc < 0) alu_gnt_cyc = c;
      if (wr_inc === 1'b1 && n_wr < 8) begin
        wr_log[n_wr] = wr_data;
        n_wr++;
      end
      next_cycle();
      if (g_rf)  req_rf  = 1'b0;
      if (g_alu) req_alu = 1'b0;
    end
    total++; if (n_wr !== 3) begin bad++; $display("FAIL b2b_write_count got=%0d exp=3", n_wr); end
    if (n_wr >= 3) begin
      total++; if (wr_log[0] !== 8'h11) begin bad++; $display("FAIL b2b_word0 got=%h exp=11", wr_log[0]); end
      total++; if (wr_log[1] !== 8'h33) begin bad++; $display("FAIL b2b_word1 got=%h exp=33", wr_log[1]); end
      total++; if (wr_log[2] !== 8'h22) begin bad++; $display("FAIL b2b_word2 got=%h exp=22", wr_log[2]); end
    end
    total++; if (alu_gnt_cyc !== 2) begin bad++; $display("FAIL b2b_alu_gnt_cycle got=%0d exp=2", alu_gnt_cyc); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL b2b_gnt_overlap got=%0d exp=0", overlap); end
  endtask

  // Both requests held high continuously from reset: order of first 4 grants.
  task automatic test_tie_break();
    logic [3:0] seq;
    logic [3:0] exp_seq;
    int         n_gnt;
    n_gnt = 0;
    seq   = 4'b0000;
`ifdef ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    do_reset();
    req_rf   = 1'b1;
    rf_data  = 8'h11;
    req_alu  = 1'b1;
    alu_data = 16'h2233;
    for (int c = 0; c < 10; c++) begin
      to_sample();
      if ((gnt_rf === 1'b1 || gnt_alu === 1'b1) && n_gnt < 4) begin
        seq[n_gnt] = gnt_alu;
        n_gnt++;
      end
      next_cycle();
    end
    total++; if (n_gnt !== 4) begin bad++; $display("FAIL tie_grant_count got=%0d exp=4", n_gnt); end
    total++; if (seq !== exp_seq) begin bad++; $display("FAIL tie_grant_order got=%b exp=%b (bit i=1 means ALU)", seq, exp_seq); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_alu   = 1'b1;
    alu_data  = 16'hBEEF;
    fifo_full = 1'b1;
    to_sample();
    total++; if (gnt_alu !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", gnt_alu); end
    next_cycle();
    to_sample();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_lo got=%b exp=1", busy); end
    total++; if (wr_data !== 8'hEF) begin bad++; $display("FAIL rmid_lo_data got=%h exp=ef", wr_data); end
    #1 rst = 1'b1;
    fifo_full = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy_now got=%b exp=0", busy); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rmid_data_now got=%h exp=00", wr_data); end
    total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL rmid_wr_inc_now got=%b exp=0", wr_inc); end
    total++; if (gnt_alu !== 1'b0) begin bad++; $display("FAIL rmid_gnt_now got=%b exp=0", gnt_alu); end
    next_cycle();
    to_sample();
    total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL rmid_wr_inc_in_reset got=%b exp=0", wr_inc); end
    next_cycle();
    rst = 1'b0;
    to_sample();
    total++; if (gnt_alu !== 1'b1) begin bad++; $display("FAIL rmid_regrant got=%b exp=1", gnt_alu); end
    total++; if (wr_inc !== 1'b0) begin bad++; $display("FAIL rmid_regrant_wr_inc got=%b exp=0", wr_inc); end
    next_cycle();
    req_alu = 1'b0;
    to_sample();
    total++; if (wr_inc !== 1'b1 || wr_data !== 8'hEF) begin bad++; $display("FAIL rmid_lo got=%b/%h exp=1/ef", wr_inc, wr_data); end
    next_cycle();
    to_sample();
    total++; if (wr_inc !== 1'b1 || wr_data !== 8'hBE) begin bad++; $display("FAIL rmid_hi got=%b/%h exp=1/be", wr_inc, wr_data); end
    next_cycle();
    to_sample();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_end_busy got=%b exp=0", busy); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_rf_single();
    test_alu_two_words();
    test_stall_hi();
    test_back_to_back();
    test_tie_break();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one FIFO write word and of RF_DATA.
REQ-002 Parameter ALU_OUT_WIDTH, default 16: width of ALU_DATA; SHALL equal 2*DATA_WIDTH.
REQ-003 CLK  in  1  single block clock; all state changes on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 REQ_RF  in  1  register-file read-response requester, one word to send.
REQ-006 RF_DATA  in  DATA_WIDTH  register-file word; valid while REQ_RF=1.
REQ-007 GNT_RF  out  1  one-cycle accept pulse to the register-file requester.
REQ-008 REQ_ALU  in  1  ALU-result requester, two words to send.
REQ-009 ALU_DATA  in  ALU_OUT_WIDTH  ALU result; valid while REQ_ALU=1.
REQ-010 GNT_ALU  out  1  one-cycle accept pulse to the ALU requester.
REQ-011 FIFO_FULL  in  1  TX FIFO full flag, write-domain synchronised.
REQ-012 WR_DATA  out  DATA_WIDTH  FIFO write data.
REQ-013 WR_INC  out  1  FIFO write strobe; one word written per cycle high.
REQ-014 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEND_RF, SEND_ALU_LO and SEND_ALU_HI.
REQ-016 IDLE with any request high: grant exactly one requester, assert its GNT combinationally that cycle, and capture its data into a DATA_WIDTH*2 holding register at the edge.
REQ-017 Transitions: IDLE->SEND_RF on a GNT_RF; IDLE->SEND_ALU_LO on a GNT_ALU; IDLE->IDLE with no request.
REQ-018 Each SEND state SHALL hold while FIFO_FULL=1.
REQ-019 When FIFO_FULL=0: SEND_ALU_LO->SEND_ALU_HI; SEND_ALU_HI->IDLE; SEND_RF->IDLE.
REQ-020 WR_INC SHALL equal (state is SEND_*) AND NOT FIFO_FULL; it is never high in IDLE.
REQ-021 WR_DATA SHALL equal the held RF word in SEND_RF, ALU_DATA[DATA_WIDTH-1:0] in SEND_ALU_LO, ALU_DATA[ALU_OUT_WIDTH-1:DATA_WIDTH] in SEND_ALU_HI, and 0 in IDLE.
REQ-022 WR_DATA SHALL stay stable while a SEND state is stalled by FIFO_FULL.
REQ-023 Latency: grant in cycle N gives the first WR_INC no earlier than N+1.
REQ-024 An ALU transaction SHALL write the low word then the high word, never interleaved with another transaction.
REQ-025 GNT_RF and GNT_ALU SHALL never be high together and SHALL be low outside IDLE.
REQ-026 Requesters hold REQ until granted; requests seen outside IDLE are ignored, not queued.
REQ-027 Inputs REQ_*/data changing after grant SHALL NOT affect the words written.
REQ-028 There SHALL be exactly one IDLE cycle between back-to-back transactions.
REQ-029 Both requests high in IDLE: the winner is chosen per REQ-033/REQ-034.

Reset
REQ-030 RST=1 SHALL immediately force IDLE and clear the holding register, with GNT_RF=GNT_ALU=0, WR_INC=0, WR_DATA=0, BUSY=0 and the round-robin pointer favouring RF.
REQ-031 Reset mid-transaction SHALL discard the remaining words with no further WR_INC; the requester re-requests after release.
REQ-032 The first grant is possible in the first clock edge after RST deasserts.

Configuration
REQ-033 Macro ARB_RR_EN undefined: fixed priority, RF beats ALU on simultaneous requests.
REQ-034 ARB_RR_EN defined: 1-bit round-robin pointer, winner is the requester the pointer favours.
REQ-035 Pointer update: after each grant the pointer favours the other requester; a lone request is always granted regardless of pointer.

Verification
REQ-036 REQ_RF=1 with RF_DATA=0x5A and FIFO_FULL=0 -> GNT_RF pulse in cycle N, then in N+1 WR_INC=1 and WR_DATA=0x5A, then IDLE in N+2 with BUSY=0.
REQ-037 REQ_ALU=1 with ALU_DATA=0xBEEF -> GNT_ALU pulse, then WR_INC=1 on two consecutive cycles with WR_DATA=0xEF then 0xBE.
REQ-038 FIFO_FULL=1 for 3 cycles on entry to SEND_ALU_HI -> WR_DATA held at 0xBE with WR_INC=0 for 3 cycles, then one WR_INC with 0xBE.
REQ-039 Both requests held through two rounds (RF=0x11, ALU=0x2233) -> without ARB_RR_EN the write sequence is 0x11,0x33,0x22; with ARB_RR_EN, two further rounds from reset alternate RF, ALU, RF, ALU.
REQ-040 RST pulsed while in SEND_ALU_LO with FIFO_FULL=1 -> all outputs 0 immediately and no WR_INC afterwards; after release, a held REQ_ALU is regranted and writes both words.
